// File: rtl/nand_1_pkg.sv
// nand_1_pkg: shared defaults and types for the nand_1 reference NAND block.
//   NAND_1_DEF_WIDTH : default number of independent NAND lanes
//   NAND_1_DEF_CNT_W : default width of the transition counter
//   nand_1_cnt_t     : counter type at the default width
package nand_1_pkg;

  localparam int unsigned NAND_1_DEF_WIDTH = 1;
  localparam int unsigned NAND_1_DEF_CNT_W = 16;

  typedef logic [NAND_1_DEF_CNT_W-1:0] nand_1_cnt_t;

endpackage

// File: rtl/nand_1_if.sv
// nand_1_if: operand/result bundle for nand_1.
//   en         : capture enable for out_q
//   in1, in2   : NAND operands, one bit per lane
//   out        : combinational NAND result
//   out_q      : registered copy of out
//   toggle_cnt : saturating count of cycles in which out_q changed
//   all_low    : registered flag, every lane of out_q is 0
// Modports: master drives operands and enable, slave (the block) drives results.
interface nand_1_if
  import nand_1_pkg::*;
#(
  parameter int unsigned WIDTH = NAND_1_DEF_WIDTH,
  parameter int unsigned CNT_W = NAND_1_DEF_CNT_W
);

  logic             en;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] toggle_cnt;
  logic             all_low;

  modport master (
    output en, in1, in2,
    input  out, out_q, toggle_cnt, all_low
  );

  modport slave (
    input  en, in1, in2,
    output out, out_q, toggle_cnt, all_low
  );

endinterface

// File: rtl/nand_1_cell.sv
// nand_1_cell: one-bit NAND.
//   in1_i : first operand, gates the pull-down device nearest the output
//   in2_i : second operand, gates the pull-down device nearest ground
//   out_o : ~(in1_i & in2_i), never tri-stated
// With NAND_1_SWITCH_LEVEL_EN defined the cell is built from pmos/nmos devices on
// supply rails with internal series node w1; otherwise it is a plain assignment.
// Both forms give 1 whenever either input is 0, and X otherwise on an unknown input.
module nand_1_cell (
  input  wire in1_i,
  input  wire in2_i,
  output wire out_o
);

`ifdef NAND_1_SWITCH_LEVEL_EN
  supply1 vdd;
  supply0 gnd;
  wire    w1;

  // Parallel pull-ups: either input low pulls out_o high.
  pmos u_pu1 (out_o, vdd, in1_i);
  pmos u_pu2 (out_o, vdd, in2_i);

  // Series pull-down through w1: both inputs high pull out_o low.
  nmos u_pd1 (out_o, w1, in1_i);
  nmos u_pd2 (w1, gnd, in2_i);
`else
  assign out_o = ~(in1_i & in2_i);
`endif

endmodule

// File: rtl/nand_1.sv
// nand_1: reference WIDTH-lane NAND primitive with registered copy and
// saturating transition counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : nand_1_if slave (en, in1, in2 in; out, out_q, toggle_cnt, all_low out)
// Build option NAND_1_SWITCH_LEVEL_EN: build out from switch-level nand_1_cell
// instances instead of a continuous assignment.
module nand_1
  import nand_1_pkg::*;
#(
  parameter int unsigned WIDTH = NAND_1_DEF_WIDTH,
  parameter int unsigned CNT_W = NAND_1_DEF_CNT_W
) (
  input logic     clk,
  input logic     rst_n,
  nand_1_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  wire  [WIDTH-1:0] nand_w;

  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             all_low_q, all_low_d;

`ifdef NAND_1_SWITCH_LEVEL_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    nand_1_cell u_cell (
      .in1_i (bus.in1[i]),
      .in2_i (bus.in2[i]),
      .out_o (nand_w[i])
    );
  end
`else
  assign nand_w = ~(bus.in1 & bus.in2);
`endif

  assign bus.out = nand_w;

  always_comb begin
    out_q_d   = out_q_q;
    cnt_d     = cnt_q;
    all_low_d = all_low_q;
    if (bus.en) begin
      out_q_d   = nand_w;
      all_low_d = (nand_w == '0);
      // Count only loads that change at least one lane; hold at the maximum.
      if ((nand_w != out_q_q) && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset value of out_q is all ones: the NAND of idle (00) operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q   <= '1;
      cnt_q     <= '0;
      all_low_q <= 1'b0;
    end else begin
      out_q_q   <= out_q_d;
      cnt_q     <= cnt_d;
      all_low_q <= all_low_d;
    end
  end

  assign bus.out_q      = out_q_q;
  assign bus.toggle_cnt = cnt_q;
  assign bus.all_low    = all_low_q;

endmodule

// File: tb/tb_nand_1.sv
// tb_nand_1: scoreboard bench for nand_1 (WIDTH = 2, CNT_W = 2).
// Each step drives inputs just after a rising edge and queues hand-computed
// expectations; the monitor pops and compares at the following falling edge.
module tb_nand_1;

  localparam int unsigned W  = 2;
  localparam int unsigned CW = 2;

  typedef struct {
    int           idx;
    logic [W-1:0] out;
    logic [W-1:0] q;
    logic [CW-1:0] cnt;
    logic         al;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step_no = 0;

  nand_1_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  nand_1 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask

  // Monitor: compares whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out",        e.idx, 4'(bus.out),        4'(e.out));
      check("out_q",      e.idx, 4'(bus.out_q),      4'(e.q));
      check("toggle_cnt", e.idx, 4'(bus.toggle_cnt), 4'(e.cnt));
      check("all_low",    e.idx, 4'(bus.all_low),    4'(e.al));
    end
  end

  // Expected registered values are those after the edge just passed, which
  // sampled the previous step's en and operands.
  task automatic step(input logic rst, input logic en, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] eout,
                      input logic [W-1:0] eq, input logic [CW-1:0] ec, input logic eal);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = rst;
    bus.en  = en;
    bus.in1 = a;
    bus.in2 = b;
    e.idx = step_no;
    e.out = eout;
    e.q   = eq;
    e.cnt = ec;
    e.al  = eal;
    sb.push_back(e);
    step_no++;
  endtask

  initial begin
    logic [W-1:0] v;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;

    //    rst  en  in1    in2    out    out_q  cnt    all_low
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'd0, 1'b0); // 0 in reset
    step(1'b1, 1'b1, 2'b00, 2'b01, 2'b11, 2'b11, 2'd0, 1'b0); // 1 release
    step(1'b1, 1'b0, 2'b01, 2'b00, 2'b11, 2'b11, 2'd0, 1'b0); // 2 first load 11: no toggle
    step(1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b11, 2'd0, 1'b0); // 3 11 -> 0, en low
    step(1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b11, 2'd0, 1'b0); // 4 holds
    step(1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'd0, 1'b0); // 5 raise en
    step(1'b1, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'd1, 1'b1); // 6 captured 00
    step(1'b1, 1'b1, 2'b01, 2'b10, 2'b11, 2'b11, 2'd2, 1'b0); // 7
    step(1'b1, 1'b1, 2'b11, 2'b01, 2'b10, 2'b11, 2'd2, 1'b0); // 8 same value: no count
    step(1'b1, 1'b1, 2'b10, 2'b11, 2'b01, 2'b10, 2'd3, 1'b0); // 9
    step(1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b01, 2'd3, 1'b0); // 10 saturated
    step(1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 2'd3, 1'b1); // 11
    step(1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'd3, 1'b1); // 12 hold with out_q = 0
    step(1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'd0, 1'b0); // 13 async reset mid-cycle
    step(1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'd0, 1'b0); // 14 edge was in reset
    step(1'b1, 1'b1, 2'b00, 2'b10, 2'b11, 2'b00, 2'd1, 1'b1); // 15
    step(1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'd2, 1'b0); // 16
    step(1'b1, 1'b0, 2'b00, 2'bxx, 2'b11, 2'b00, 2'd3, 1'b1); // 17 0 forces 1 over X
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'd3, 1'b1); // 18

    // Both operands toggling together with capture disabled.
    for (int i = 0; i < 50; i++) begin
      v = (i % 2 == 0) ? 2'b00 : 2'b11;
      step(1'b1, 1'b0, v, v, ~v, 2'b00, 2'd3, 1'b1);
    end

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
